// File: rtl/arcade_input_cond.sv
// Per-player input conditioner between hps_io joystick words and the game core:
// debounces buttons/start/coin and shapes coin presses into timed, queued pulses.
module arcade_input_cond #(
  parameter int NPLAYERS   = 2,
  parameter int NBUTTONS   = 1,
  parameter int BTN_BASE   = 4,
  parameter int DEB_TICKS  = 8,
  parameter int COIN_TICKS = 16,
  parameter int GAP_TICKS  = 16,
  parameter int QDEPTH     = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic [16*NPLAYERS-1:0]       joy_in,
  output logic [NBUTTONS*NPLAYERS-1:0] btn_out,
  output logic [NPLAYERS-1:0]          start_out,
  output logic [NPLAYERS-1:0]          coin_out,
  output logic [2*NPLAYERS-1:0]        coin_pend
);

  // state   | meaning
  // S_IDLE  | no coin in progress, coin_out low
  // S_PULSE | coin_out high for COIN_TICKS ce ticks
  // S_GAP   | coin_out low for GAP_TICKS ce ticks, then serve queue or idle
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} coin_state_t;

  // Debounced bits per player: buttons, then start, then coin (topmost).
  localparam int NB   = NBUTTONS + 2;
  localparam int DW   = (DEB_TICKS > 0) ? $clog2(DEB_TICKS + 1) : 1;
  localparam int TMAX = (COIN_TICKS > GAP_TICKS) ? COIN_TICKS : GAP_TICKS;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [CW-1:0] COIN_LAST = CW'(COIN_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
  localparam logic [2:0]    QMAX      = 3'(QDEPTH);

  logic [16*NPLAYERS-1:0] raw_q, raw_d;
  logic [NB-1:0]          stab_q [NPLAYERS];
  logic [NB-1:0]          stab_d [NPLAYERS];
  logic [DW-1:0]          dcnt_q [NPLAYERS][NB];
  logic [DW-1:0]          dcnt_d [NPLAYERS][NB];
  logic [NPLAYERS-1:0]    coin_dly_q, coin_dly_d;
  logic [NPLAYERS-1:0]    rise;
  coin_state_t            st_q   [NPLAYERS];
  coin_state_t            st_d   [NPLAYERS];
  logic [CW-1:0]          tcnt_q [NPLAYERS];
  logic [CW-1:0]          tcnt_d [NPLAYERS];
  logic [1:0]             pend_q [NPLAYERS];
  logic [1:0]             pend_d [NPLAYERS];
  logic [2:0]             qsum;

  // Only a slice of each joystick word is conditioned; the rest is ignored.
  logic unused_raw;
  assign unused_raw = ^raw_q;

  always_comb begin
    raw_d = joy_in;
    for (int p = 0; p < NPLAYERS; p++) begin
      for (int b = 0; b < NB; b++) begin
        stab_d[p][b] = stab_q[p][b];
        dcnt_d[p][b] = '0;
        if (DEB_TICKS == 0) begin
          stab_d[p][b] = raw_q[16*p + BTN_BASE + b];
        end else if (raw_q[16*p + BTN_BASE + b] != stab_q[p][b]) begin
          dcnt_d[p][b] = dcnt_q[p][b];
          if (ce) begin
            if (dcnt_q[p][b] == DEB_LAST) begin
              stab_d[p][b] = raw_q[16*p + BTN_BASE + b];
              dcnt_d[p][b] = '0;
            end else begin
              dcnt_d[p][b] = dcnt_q[p][b] + 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    qsum = '0;
    for (int p = 0; p < NPLAYERS; p++) begin
      coin_dly_d[p] = stab_q[p][NB-1];
      rise[p]       = stab_q[p][NB-1] & ~coin_dly_q[p];
      st_d[p]       = st_q[p];
      tcnt_d[p]     = tcnt_q[p];
      pend_d[p]     = pend_q[p];
      // A rise outside IDLE joins the queue; saturation is applied after any
      // same-cycle dequeue so a full queue still accepts a coin it frees room for.
      qsum = 3'(pend_q[p]) + 3'((st_q[p] != S_IDLE) && rise[p]);
      case (st_q[p])
        S_IDLE: begin
          tcnt_d[p] = '0;
          if (rise[p]) begin
            st_d[p] = S_PULSE;
          end else if (pend_q[p] != 2'd0) begin
            st_d[p] = S_PULSE;
            qsum    = qsum - 3'd1;
          end
        end
        S_PULSE: begin
          if (ce) begin
            if (tcnt_q[p] == COIN_LAST) begin
              st_d[p]   = S_GAP;
              tcnt_d[p] = '0;
            end else begin
              tcnt_d[p] = tcnt_q[p] + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (ce) begin
            if (tcnt_q[p] == GAP_LAST) begin
              tcnt_d[p] = '0;
              if (qsum != 3'd0) begin
                st_d[p] = S_PULSE;
                qsum    = qsum - 3'd1;
              end else begin
                st_d[p] = S_IDLE;
              end
            end else begin
              tcnt_d[p] = tcnt_q[p] + 1'b1;
            end
          end
        end
        default: begin
          st_d[p]   = S_IDLE;
          tcnt_d[p] = '0;
        end
      endcase
      if (qsum > QMAX) qsum = QMAX;
      pend_d[p] = qsum[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q      <= '0;
      coin_dly_q <= '0;
      for (int p = 0; p < NPLAYERS; p++) begin
        stab_q[p] <= '0;
        st_q[p]   <= S_IDLE;
        tcnt_q[p] <= '0;
        pend_q[p] <= '0;
        for (int b = 0; b < NB; b++) dcnt_q[p][b] <= '0;
      end
    end else begin
      raw_q      <= raw_d;
      coin_dly_q <= coin_dly_d;
      for (int p = 0; p < NPLAYERS; p++) begin
        stab_q[p] <= stab_d[p];
        st_q[p]   <= st_d[p];
        tcnt_q[p] <= tcnt_d[p];
        pend_q[p] <= pend_d[p];
        for (int b = 0; b < NB; b++) dcnt_q[p][b] <= dcnt_d[p][b];
      end
    end
  end

  always_comb begin
    btn_out   = '0;
    start_out = '0;
    coin_out  = '0;
    coin_pend = '0;
    for (int p = 0; p < NPLAYERS; p++) begin
      btn_out[NBUTTONS*p +: NBUTTONS] = stab_q[p][NBUTTONS-1:0];
      start_out[p]                    = stab_q[p][NBUTTONS];
      coin_out[p]                     = (st_q[p] == S_PULSE);
      coin_pend[2*p +: 2]             = pend_q[p];
    end
  end

endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed bench for arcade_input_cond with default parameters: debounce,
// coin pulse shaping and queueing, reset mid-pulse and ce freeze.
module tb_arcade_input_cond;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [31:0] joy_in;
  logic [1:0]  btn_out;
  logic [1:0]  start_out;
  logic [1:0]  coin_out;
  logic [3:0]  coin_pend;

  int n_cmp = 0;
  int n_bad = 0;
  int npulse;
  logic prev_coin;

  arcade_input_cond dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .joy_in    (joy_in),
    .btn_out   (btn_out),
    .start_out (start_out),
    .coin_out  (coin_out),
    .coin_pend (coin_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One timebase tick: a plain edge (registers joy_in), the ce edge, and a
  // trailing edge on which any resulting coin rise is acted upon.
  task automatic tick();
    ce = 1'b0; cyc();
    ce = 1'b1; cyc();
    ce = 1'b0; cyc();
  endtask

  // Hand-derived queue depth for the nine-press burst on player 1.
  function automatic int exp_pend(input int t);
    if (t < 24)       return 0;
    else if (t < 56)  return 1;
    else if (t < 88)  return 2;
    else if (t < 168) return 3;
    else if (t < 200) return 2;
    else if (t < 232) return 1;
    else              return 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    ce     = 1'b1;
    joy_in = '1;
    cyc(); cyc(); cyc();
    chk("rst_btn",   32'(btn_out),   32'd0);
    chk("rst_start", 32'(start_out), 32'd0);
    chk("rst_coin",  32'(coin_out),  32'd0);
    chk("rst_pend",  32'(coin_pend), 32'd0);

    reset = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      chk("rel_btn_early",   32'(btn_out),   32'd0);
      chk("rel_start_early", 32'(start_out), 32'd0);
    end
    tick();
    chk("rel_btn_8",   32'(btn_out),   32'h3);
    chk("rel_start_8", 32'(start_out), 32'h3);
    chk("rel_coin_8",  32'(coin_out),  32'h3);

    joy_in = '0;
    reset  = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst2_coin", 32'(coin_out), 32'd0);
    chk("rst2_btn",  32'(btn_out),  32'd0);

    // 5-tick glitch on player 1 button must never be accepted.
    for (int t = 1; t <= 12; t++) begin
      joy_in[4] = (t <= 5);
      tick();
      chk("glitch_btn", 32'(btn_out), 32'd0);
    end
    for (int t = 1; t <= 10; t++) begin
      joy_in[4] = 1'b1;
      tick();
      chk("hold_btn0", 32'(btn_out[0]), 32'(t >= 8));
      chk("hold_btn1", 32'(btn_out[1]), 32'd0);
      chk("hold_start", 32'(start_out), 32'd0);
    end
    for (int t = 1; t <= 10; t++) begin
      joy_in[4] = 1'b0;
      tick();
      chk("rel_btn0", 32'(btn_out[0]), 32'(t < 8));
    end

    // Single coin on player 2, held 24 ticks.
    for (int t = 1; t <= 60; t++) begin
      joy_in[22] = (t <= 24);
      tick();
      chk("p2_coin",  32'(coin_out[1]),    32'(t >= 8 && t < 24));
      chk("p2_pend",  32'(coin_pend[3:2]), 32'd0);
      chk("p2_other", 32'(coin_out[0]),    32'd0);
    end

    // Nine presses on player 1, 8 ticks high / 8 low: queue saturates at 3,
    // the press at tick 120 is dropped, eight pulses come out.
    npulse    = 0;
    prev_coin = 1'b0;
    for (int t = 1; t <= 280; t++) begin
      joy_in[6] = (t <= 144) && (((t - 1) % 16) < 8);
      tick();
      chk("burst_coin", 32'(coin_out[0]),
          32'(t >= 8 && t < 264 && ((t - 8) % 32) < 16));
      chk("burst_pend", 32'(coin_pend[1:0]), 32'(exp_pend(t)));
      chk("burst_p2",   32'(coin_out[1]),    32'd0);
      if (coin_out[0] && !prev_coin) npulse++;
      prev_coin = coin_out[0];
    end
    chk("burst_npulse", 32'(npulse), 32'd8);

    // Same burst, reset during the third pulse with two coins queued.
    for (int t = 1; t <= 75; t++) begin
      joy_in[6] = (((t - 1) % 16) < 8);
      tick();
    end
    chk("pre_rst_coin", 32'(coin_out[0]),    32'd1);
    chk("pre_rst_pend", 32'(coin_pend[1:0]), 32'd2);
    joy_in[6] = 1'b0;
    reset     = 1'b1;
    cyc();
    chk("mid_rst_coin", 32'(coin_out),  32'd0);
    chk("mid_rst_pend", 32'(coin_pend), 32'd0);
    reset = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      chk("post_rst_coin", 32'(coin_out),  32'd0);
      chk("post_rst_pend", 32'(coin_pend), 32'd0);
    end

    // ce frozen for 100 cycles after 5 pulse samples; remaining ticks resume.
    for (int t = 1; t <= 12; t++) begin
      joy_in[6] = (t <= 8);
      tick();
      chk("frz_pre", 32'(coin_out[0]), 32'(t >= 8));
    end
    ce = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (i % 25 == 24) chk("frz_hold", 32'(coin_out[0]), 32'd1);
    end
    chk("frz_pend", 32'(coin_pend), 32'd0);
    for (int t = 13; t <= 30; t++) begin
      tick();
      chk("frz_resume", 32'(coin_out[0]), 32'(t < 24));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
